// File: rtl/ohc7_pkg.sv
// Shared constants and helpers for the mod-7 one-hot residue decoder.
// Combinational helpers only; no latency or backpressure involved.
package ohc7_pkg;
    localparam int OHC_W = 7;
    localparam int BIN_W = 3;
    localparam int MOD   = 7;
    localparam logic [BIN_W-1:0] BIN_INVALID = 3'd7;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    function automatic logic is_onehot7(input logic [OHC_W-1:0] v);
        return (v != '0) && ((v & (v - 7'd1)) == '0);
    endfunction
endpackage

// File: rtl/ohc7_to_binary_if.sv
// Stream and error-status bundle for the one-hot to binary decoder.
// master drives words and out_ready; slave (decoder) drives results and in_ready.
interface ohc7_to_binary_if
    import ohc7_pkg::*;
#(
    parameter int ERR_CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [OHC_W-1:0]     in_ohc;
    logic                 out_valid;
    logic                 out_ready;
    logic [BIN_W-1:0]     out_bin;
    logic                 out_err;
    logic                 err_clr;
    logic [ERR_CNT_W-1:0] err_count;
    logic                 err_sticky;

    modport master (
        output in_valid, in_ohc, out_ready, err_clr,
        input  in_ready, out_valid, out_bin, out_err, err_count, err_sticky
    );

    modport slave (
        input  in_valid, in_ohc, out_ready, err_clr,
        output in_ready, out_valid, out_bin, out_err, err_count, err_sticky
    );
endinterface

// File: rtl/ohc7_decode.sv
// One-hot (mod 7) to binary decode with malformed-word flag.
// Purely combinational, zero latency, no backpressure.
module ohc7_decode
    import ohc7_pkg::*;
(
    input  logic [OHC_W-1:0] ohc_i,
    output logic [BIN_W-1:0] bin_o,
    output logic             err_o
);
    // Any pattern that is not a single set bit lands in default, so no X escapes.
    always_comb begin
        bin_o = BIN_INVALID;
        unique case (ohc_i)
            7'b000_0001: bin_o = 3'd0;
            7'b000_0010: bin_o = 3'd1;
            7'b000_0100: bin_o = 3'd2;
            7'b000_1000: bin_o = 3'd3;
            7'b001_0000: bin_o = 3'd4;
            7'b010_0000: bin_o = 3'd5;
            7'b100_0000: bin_o = 3'd6;
            default:     bin_o = BIN_INVALID;
        endcase
        err_o = !is_onehot7(ohc_i);
    end
endmodule

// File: rtl/ohc7_to_binary.sv
// Two-stage valid/ready decoder: raw word in S1, decoded result in S2, 2-cycle latency.
// in_ready drops only when both stages are full and out_ready is low; errors counted on S2 load.
module ohc7_to_binary
    import ohc7_pkg::*;
#(
    parameter int ERR_CNT_W = 8
)
(
    input  logic              clk,
    input  logic              rst_n,
    ohc7_to_binary_if.slave   bus
);
    localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    logic                 s1_v_q, s1_v_d;
    logic [OHC_W-1:0]     s1_ohc_q, s1_ohc_d;
    logic                 out_v_q, out_v_d;
    logic [BIN_W-1:0]     bin_q, bin_d;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
    logic                 sticky_q, sticky_d;

    logic [BIN_W-1:0]     dec_bin;
    logic                 dec_err;
    logic                 s2_load;
    logic                 in_acc;
    logic                 err_load;

    ohc7_decode u_decode (
        .ohc_i (s1_ohc_q),
        .bin_o (dec_bin),
        .err_o (dec_err)
    );

    assign s2_load      = !out_v_q || bus.out_ready;
    assign bus.in_ready = !s1_v_q || s2_load;
    assign in_acc       = bus.in_valid && bus.in_ready;
    assign err_load     = s2_load && s1_v_q && dec_err;

    always_comb begin
        s1_v_d   = s1_v_q;
        s1_ohc_d = s1_ohc_q;
        out_v_d  = out_v_q;
        bin_d    = bin_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;

        if (s2_load) begin
            out_v_d = s1_v_q;
            s1_v_d  = 1'b0;
            if (s1_v_q) begin
                bin_d = dec_bin;
                err_d = dec_err;
            end
        end
        if (in_acc) begin
            s1_v_d   = 1'b1;
            s1_ohc_d = bus.in_ohc;
        end

        // Clear first so a same-cycle error still leaves a count of one.
        if (bus.err_clr) begin
            cnt_d    = '0;
            sticky_d = 1'b0;
        end
        if (err_load) begin
            sticky_d = 1'b1;
            if (cnt_d != '1) cnt_d = cnt_d + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q   <= 1'b0;
            s1_ohc_q <= '0;
            out_v_q  <= 1'b0;
            bin_q    <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            s1_v_q   <= s1_v_d;
            s1_ohc_q <= s1_ohc_d;
            out_v_q  <= out_v_d;
            bin_q    <= bin_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    assign bus.out_valid  = out_v_q;
    assign bus.out_bin    = bin_q;
    assign bus.out_err    = err_q;
    assign bus.err_count  = cnt_q;
    assign bus.err_sticky = sticky_q;
endmodule

// File: tb/tb_ohc7_to_binary.sv
// Bench for ohc7_to_binary: directed table, stall/reset/saturation sequences, random scoreboard.
// Two DUTs share stimulus: one with an 8-bit error counter, one with a 2-bit counter.
module tb_ohc7_to_binary;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic       err_clr;
    logic [6:0] in_ohc;

    always #5 clk = ~clk;

    ohc7_to_binary_if #(.ERR_CNT_W(8)) bus8();
    ohc7_to_binary_if #(.ERR_CNT_W(2)) bus2();

    assign bus8.in_valid  = in_valid;
    assign bus8.in_ohc    = in_ohc;
    assign bus8.out_ready = out_ready;
    assign bus8.err_clr   = err_clr;
    assign bus2.in_valid  = in_valid;
    assign bus2.in_ohc    = in_ohc;
    assign bus2.out_ready = out_ready;
    assign bus2.err_clr   = err_clr;

    ohc7_to_binary #(.ERR_CNT_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    ohc7_to_binary #(.ERR_CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    typedef struct {
        logic [6:0] ohc;
        logic [2:0] bin;
        logic       err;
    } vec_t;

    typedef struct {
        logic [2:0] bin;
        logic       err;
        int         cum;
    } exp_t;

    int   tests = 0;
    int   fails = 0;
    exp_t q[$];
    int   cum;
    int   inflight;
    int   popped;
    logic acc_g;
    logic stall_q;
    logic [2:0] held_bin;
    logic       held_err;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: count set bits; a single set bit gives its position.
    task automatic model_dec(input logic [6:0] v, output logic [2:0] b, output logic e);
        int n;
        int idx;
        n = 0;
        idx = 0;
        for (int k = 0; k < 7; k++) begin
            if (v[k]) begin
                n++;
                idx = k;
            end
        end
        e = (n != 1);
        b = e ? 3'd7 : 3'(idx);
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_ohc    = '0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        cum      = 0;
        inflight = 0;
        popped   = 0;
        stall_q  = 1'b0;
    endtask

    // One clock of scoreboard checking; inputs must already be driven.
    task automatic sb_cycle();
        exp_t       e;
        logic [2:0] b;
        logic       eb;
        @(negedge clk);
        acc_g = in_valid && bus8.in_ready;
        check("in_ready", int'(bus8.in_ready), int'(!(inflight == 2 && !out_ready)));
        if (stall_q) begin
            check("hold_bin", int'(bus8.out_bin), int'(held_bin));
            check("hold_err", int'(bus8.out_err), int'(held_err));
        end
        if (bus8.out_valid && out_ready) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_out: got out_bin %0d expected no word", bus8.out_bin);
            end else begin
                e = q.pop_front();
                check("out_bin", int'(bus8.out_bin), int'(e.bin));
                check("out_err", int'(bus8.out_err), int'(e.err));
                check("err_count", int'(bus8.err_count), sat(e.cum, 255));
                check("err_count_w2", int'(bus2.err_count), sat(e.cum, 3));
                check("err_sticky", int'(bus8.err_sticky), int'(e.cum > 0));
            end
            popped++;
            inflight--;
        end
        stall_q  = bus8.out_valid && !out_ready;
        held_bin = bus8.out_bin;
        held_err = bus8.out_err;
        if (acc_g) begin
            model_dec(in_ohc, b, eb);
            cum += int'(eb);
            q.push_back('{bin: b, err: eb, cum: cum});
            inflight++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t       tbl[10];
        logic [6:0] words[10];
        logic [6:0] bad[5];
        int         sent;
        int         cyc;

        for (int k = 0; k < 7; k++) begin
            tbl[k].ohc = 7'(1 << k);
            tbl[k].bin = 3'(k);
            tbl[k].err = 1'b0;
        end
        tbl[7] = '{ohc: 7'b0000000, bin: 3'd7, err: 1'b1};
        tbl[8] = '{ohc: 7'b0000011, bin: 3'd7, err: 1'b1};
        tbl[9] = '{ohc: 7'b1111111, bin: 3'd7, err: 1'b1};
        bad[0] = 7'b0000000; bad[1] = 7'b0000011; bad[2] = 7'b1111111;
        bad[3] = 7'b0010001; bad[4] = 7'b1100000;

        // Reset state
        do_reset();
        check("rst_out_valid", int'(bus8.out_valid), 0);
        check("rst_out_bin", int'(bus8.out_bin), 0);
        check("rst_out_err", int'(bus8.out_err), 0);
        check("rst_err_count", int'(bus8.err_count), 0);
        check("rst_err_sticky", int'(bus8.err_sticky), 0);
        check("rst_in_ready", int'(bus8.in_ready), 1);

        // Back-to-back table stream, out_ready high: output i shows after edge i+2
        out_ready = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) begin
                in_valid = 1'b1;
                in_ohc   = tbl[i].ohc;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            if (i == 0) begin
                check("lat_not_yet", int'(bus8.out_valid), 0);
            end else begin
                check("tbl_valid", int'(bus8.out_valid), 1);
                check("tbl_bin", int'(bus8.out_bin), int'(tbl[i-1].bin));
                check("tbl_err", int'(bus8.out_err), int'(tbl[i-1].err));
            end
            check("tbl_in_ready", int'(bus8.in_ready), 1);
        end
        check("tbl_err_count", int'(bus8.err_count), 3);
        check("tbl_err_count_w2", int'(bus2.err_count), 3);
        check("tbl_err_sticky", int'(bus8.err_sticky), 1);

        // out_ready toggling 1,0,0,1 with a continuous input stream
        do_reset();
        for (int i = 0; i < 10; i++) words[i] = 7'(1 << $urandom_range(6, 0));
        sent = 0;
        cyc  = 0;
        while (popped < 10 && cyc < 200) begin
            in_valid  = (sent < 10);
            in_ohc    = (sent < 10) ? words[sent] : 7'd0;
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            sb_cycle();
            if (acc_g) sent++;
            cyc++;
        end
        check("stall_words_out", popped, 10);
        check("stall_queue_empty", q.size(), 0);

        // Saturation of the 2-bit counter, then clear coinciding with an error load
        do_reset();
        out_ready = 1'b1;
        sent = 0;
        cyc  = 0;
        while (popped < 5 && cyc < 100) begin
            in_valid = (sent < 5);
            in_ohc   = (sent < 5) ? bad[sent] : 7'd0;
            sb_cycle();
            if (acc_g) sent++;
            cyc++;
        end
        check("sat_words_out", popped, 5);
        check("sat_count_w2", int'(bus2.err_count), 3);
        check("sat_count_w8", int'(bus8.err_count), 5);
        in_valid = 1'b1;
        in_ohc   = 7'b0000011;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        err_clr  = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check("clr_err_count_w2", int'(bus2.err_count), 1);
        check("clr_err_count_w8", int'(bus8.err_count), 1);
        check("clr_err_sticky", int'(bus8.err_sticky), 1);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check("clr_only_count", int'(bus8.err_count), 0);
        check("clr_only_sticky", int'(bus8.err_sticky), 0);

        // Reset with both stages full
        do_reset();
        in_valid = 1'b1;
        in_ohc   = 7'b0000000;
        @(posedge clk);
        #1;
        in_ohc = 7'b0100000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("full_in_ready", int'(bus8.in_ready), 0);
        check("full_err_count", int'(bus8.err_count), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", int'(bus8.out_valid), 0);
        check("mid_rst_err_count", int'(bus8.err_count), 0);
        check("mid_rst_sticky", int'(bus8.err_sticky), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_ohc    = 7'b0001000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("post_rst_not_yet", int'(bus8.out_valid), 0);
        @(posedge clk);
        #1;
        check("post_rst_valid", int'(bus8.out_valid), 1);
        check("post_rst_bin", int'(bus8.out_bin), 3);
        check("post_rst_err", int'(bus8.out_err), 0);

        // Random traffic against the scoreboard
        do_reset();
        sent = 0;
        cyc  = 0;
        while (sent < 10000 && cyc < 40000) begin
            in_valid  = ($urandom_range(3, 0) != 0);
            in_ohc    = ($urandom_range(1, 0) == 1) ? 7'(1 << $urandom_range(6, 0))
                                                    : 7'($urandom_range(127, 0));
            out_ready = ($urandom_range(2, 0) != 0);
            sb_cycle();
            if (acc_g) sent++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (inflight > 0 && cyc < 20) begin
            sb_cycle();
            cyc++;
        end
        check("rand_words_sent", sent, 10000);
        check("rand_words_out", popped, 10000);
        check("rand_queue_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
